student_iis_slave: RTL and testbench

I2S slave transceiver: the codec-side end of the I2S link driven by `student_iis_handler`. It accepts externally generated BCLK/LRCLK, captures the serial DAC stream into parallel left/right words, and serializes parallel left/right words back onto the ADC data line. It is used as an on-chip codec model for loopback self-test and as the slave port toward external I2S masters. All logic runs in the single `clk_i` domain; the link inputs are oversampled.

---
 rtl/student_iis_pkg.sv | 13 +
 rtl/student_iis_sync.sv | 23 ++
 rtl/student_iis_slave.sv | 176 +++++++++++++++++
 tb/tb_student_iis_slave.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/student_iis_pkg.sv
// Shared types and constants for the I2S slave transceiver.
package student_iis_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } iis_state_e;

    localparam int unsigned IIS_DELAY_BITS = 1;
    localparam int unsigned IIS_CNT_W      = 5;

endpackage

// File: rtl/student_iis_sync.sv
// One-bit multi-flop synchronizer for the asynchronous I2S link inputs.
module student_iis_sync #(
    parameter int unsigned SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d,
    output logic q
);

    logic [SyncStages-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], d};
        end
    end

    assign q = sync_q[SyncStages-1];

endmodule

// File: rtl/student_iis_slave.sv
// I2S slave transceiver: oversamples BCLK/LRCLK, deserializes the DAC line
// into stereo words and serializes held stereo words onto the ADC line.
module student_iis_slave
    import student_iis_pkg::*;
#(
    parameter int unsigned DataWidth  = 16,
    parameter int unsigned SyncStages = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 bclk_i,
    input  logic                 lrclk_i,
    input  logic                 sdata_i,
    output logic                 sdata_o,
    input  logic [DataWidth-1:0] tx_l_i,
    input  logic [DataWidth-1:0] tx_r_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic [DataWidth-1:0] rx_l_o,
    output logic [DataWidth-1:0] rx_r_o,
    output logic                 rx_valid_o,
    output logic                 underrun_o,
    output logic                 frame_err_o
);

    localparam logic [IIS_CNT_W-1:0] CntFirst = IIS_CNT_W'(IIS_DELAY_BITS);
    localparam logic [IIS_CNT_W-1:0] CntLast  = IIS_CNT_W'(DataWidth + IIS_DELAY_BITS - 1);
    localparam logic [IIS_CNT_W-1:0] CntFull  = IIS_CNT_W'(DataWidth + IIS_DELAY_BITS);
    localparam logic [IIS_CNT_W-1:0] CntMax   = '1;

    logic bclk_s, lrclk_s, sdata_s;
    logic bclk_q, lr_prev_q;
    logic bclk_rise, bclk_fall, frame_start, left_start;
    logic in_slot, slot_full, accept;

    iis_state_e state_q, state_d;
    logic [IIS_CNT_W-1:0] bit_cnt_q;

    logic [DataWidth-1:0] rx_shift_q, stage_l_q;
    logic                 left_ok_q;
    logic [DataWidth-1:0] hold_l_q, hold_r_q, act_l_q, act_r_q, act_l_d, act_r_d;
    logic [DataWidth:0]   tx_shift_q;

    student_iis_sync #(.SyncStages(SyncStages)) u_sync_bclk (
        .clk_i(clk_i), .rst_ni(rst_ni), .d(bclk_i), .q(bclk_s)
    );
    student_iis_sync #(.SyncStages(SyncStages)) u_sync_lrclk (
        .clk_i(clk_i), .rst_ni(rst_ni), .d(lrclk_i), .q(lrclk_s)
    );
    student_iis_sync #(.SyncStages(SyncStages)) u_sync_sdata (
        .clk_i(clk_i), .rst_ni(rst_ni), .d(sdata_i), .q(sdata_s)
    );

    assign bclk_rise   = bclk_s & ~bclk_q;
    assign bclk_fall   = ~bclk_s & bclk_q;
    assign frame_start = bclk_fall & (lrclk_s != lr_prev_q);
    assign left_start  = frame_start & ~lrclk_s;
    assign in_slot     = (state_q != IDLE);
    assign slot_full   = (bit_cnt_q >= CntFull);
    assign accept      = tx_valid_i & tx_ready_o;

    // BCLK edge history and word-select value at the previous falling edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bclk_q    <= 1'b0;
            lr_prev_q <= 1'b0;
        end else begin
            bclk_q <= bclk_s;
            if (bclk_fall) begin
                lr_prev_q <= lrclk_s;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Channel tracking and the active pair chosen at a left frame start
    always_comb begin
        state_d = state_q;
        act_l_d = act_l_q;
        act_r_d = act_r_q;
        if (left_start && !tx_ready_o) begin
            act_l_d = hold_l_q;
            act_r_d = hold_r_q;
        end
        if (frame_start) begin
            case (state_q)
                IDLE:    if (!lrclk_s) state_d = LEFT;
                LEFT:    if (lrclk_s)  state_d = RIGHT;
                RIGHT:   if (!lrclk_s) state_d = LEFT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt_q <= '0;
        end else if (frame_start) begin
            bit_cnt_q <= '0;
        end else if (bclk_rise && (bit_cnt_q != CntMax)) begin
            bit_cnt_q <= bit_cnt_q + IIS_CNT_W'(1);
        end
    end

    // Receive path; a pair is only published when its left half was complete too
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_shift_q  <= '0;
            stage_l_q   <= '0;
            left_ok_q   <= 1'b0;
            rx_l_o      <= '0;
            rx_r_o      <= '0;
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
            if (bclk_rise && in_slot && (bit_cnt_q >= CntFirst) && (bit_cnt_q <= CntLast)) begin
                rx_shift_q <= {rx_shift_q[DataWidth-2:0], sdata_s};
            end
            if (frame_start && in_slot) begin
                if (!slot_full) begin
                    frame_err_o <= 1'b1;
                    left_ok_q   <= 1'b0;
                end else if (state_q == LEFT) begin
                    stage_l_q <= rx_shift_q;
                    left_ok_q <= 1'b1;
                end else if (left_ok_q) begin
                    rx_l_o     <= stage_l_q;
                    rx_r_o     <= rx_shift_q;
                    rx_valid_o <= 1'b1;
                    left_ok_q  <= 1'b0;
                end
            end
        end
    end

    // Transmit path: holding register, active pair and output shifter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            act_l_q    <= '0;
            act_r_q    <= '0;
            tx_shift_q <= '0;
            tx_ready_o <= 1'b1;
            underrun_o <= 1'b0;
        end else begin
            underrun_o <= left_start & tx_ready_o;
            act_l_q    <= act_l_d;
            act_r_q    <= act_r_d;
            if (accept) begin
                hold_l_q   <= tx_l_i;
                hold_r_q   <= tx_r_i;
                tx_ready_o <= 1'b0;
            end else if (left_start) begin
                tx_ready_o <= 1'b1;
            end
            if (frame_start) begin
                tx_shift_q <= {1'b0, (lrclk_s ? act_r_d : act_l_d)};
            end else if (bclk_fall) begin
                tx_shift_q <= {tx_shift_q[DataWidth-1:0], 1'b0};
            end
        end
    end

    assign sdata_o = tx_shift_q[DataWidth];

endmodule

// File: tb/tb_student_iis_slave.sv
// Scoreboard bench for student_iis_slave driven by a behavioural I2S master.
`timescale 1ns/1ps
module tb_student_iis_slave;

    localparam int unsigned DW        = 16;
    localparam int          HALF_BCLK = 8;
    localparam int          SLOT      = 32;

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_t;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          bclk_i, lrclk_i, sdata_i, sdata_o;
    logic [DW-1:0] tx_l_i, tx_r_i, rx_l_o, rx_r_o;
    logic          tx_valid_i, tx_ready_o, rx_valid_o, underrun_o, frame_err_o;

    int checks   = 0;
    int failures = 0;
    int lframe   = 0;

    pair_t         rx_exp_q[$];
    int            under_exp_q[$];
    int            ferr_exp_q[$];
    logic [DW:0]   tx_exp_q[$];
    logic [DW:0]   tx_obs_q[$];

    bit            sim_accept = 1'b0;
    logic [DW-1:0] sim_l, sim_r;

    always #5 clk_i = ~clk_i;

    student_iis_slave #(.DataWidth(DW), .SyncStages(2)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .bclk_i     (bclk_i),
        .lrclk_i    (lrclk_i),
        .sdata_i    (sdata_i),
        .sdata_o    (sdata_o),
        .tx_l_i     (tx_l_i),
        .tx_r_i     (tx_r_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .rx_l_o     (rx_l_o),
        .rx_r_o     (rx_r_o),
        .rx_valid_o (rx_valid_o),
        .underrun_o (underrun_o),
        .frame_err_o(frame_err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: actual=pulse required=none (left frame %0d)", name, lframe);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sdata_o"},     32'(sdata_o),     32'd0);
        check({tag, "_tx_ready_o"},  32'(tx_ready_o),  32'd1);
        check({tag, "_rx_l_o"},      32'(rx_l_o),      32'd0);
        check({tag, "_rx_r_o"},      32'(rx_r_o),      32'd0);
        check({tag, "_strobes"},     {29'd0, rx_valid_o, underrun_o, frame_err_o}, 32'd0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe or the master a word
    always @(negedge clk_i) begin
        pair_t p;
        if (rx_valid_o) begin
            if (rx_exp_q.size() == 0) unexpected("rx_valid");
            else begin
                p = rx_exp_q.pop_front();
                check("rx_l_o", 32'(rx_l_o), 32'(p.l));
                check("rx_r_o", 32'(rx_r_o), 32'(p.r));
            end
        end
        if (underrun_o) begin
            if (under_exp_q.size() == 0) unexpected("underrun");
            else check("underrun_frame", 32'(lframe), 32'(under_exp_q.pop_front()));
        end
        if (frame_err_o) begin
            if (ferr_exp_q.size() == 0) unexpected("frame_err");
            else check("frame_err_frame", 32'(lframe), 32'(ferr_exp_q.pop_front()));
        end
        while (tx_obs_q.size() > 0) begin
            if (tx_exp_q.size() == 0) begin
                void'(tx_obs_q.pop_front());
                unexpected("tx_capture");
            end else begin
                check("tx_word_pad", 32'(tx_obs_q.pop_front()), 32'(tx_exp_q.pop_front()));
            end
        end
    end

    // Master slot: drives LRCLK/SDATA on BCLK fall, captures sdata_o on BCLK rise
    task automatic slot(input logic lr, input logic [DW-1:0] word, input int nper,
                        input bit chk, input logic [DW-1:0] exp_tx);
        logic [DW-1:0] cap;
        logic          pad_err;
        cap     = '0;
        pad_err = 1'b0;
        if (chk) tx_exp_q.push_back({1'b0, exp_tx});
        for (int k = 0; k < nper; k++) begin
            bclk_i = 1'b0;
            if (k == 0) begin
                if (!lr && lrclk_i) lframe++;
                lrclk_i = lr;
            end
            sdata_i = (k >= 1 && k <= int'(DW)) ? word[int'(DW) - k] : 1'b0;
            if (k == 0 && sim_accept) begin
                repeat (2) @(negedge clk_i);
                tx_l_i     = sim_l;
                tx_r_i     = sim_r;
                tx_valid_i = 1'b1;
                @(negedge clk_i);
                tx_valid_i = 1'b0;
                sim_accept = 1'b0;
                repeat (HALF_BCLK - 3) @(negedge clk_i);
            end else begin
                repeat (HALF_BCLK) @(negedge clk_i);
            end
            if (k >= 1 && k <= int'(DW)) cap[int'(DW) - k] = sdata_o;
            else if (sdata_o !== 1'b0) pad_err = 1'b1;
            bclk_i = 1'b1;
            repeat (HALF_BCLK) @(negedge clk_i);
        end
        if (chk && nper == SLOT) tx_obs_q.push_back({pad_err, cap});
    endtask

    task automatic load_tx(input logic [DW-1:0] l, input logic [DW-1:0] r);
        @(negedge clk_i);
        tx_l_i     = l;
        tx_r_i     = r;
        tx_valid_i = 1'b1;
        @(negedge clk_i);
        tx_valid_i = 1'b0;
        check("tx_ready_after_accept", 32'(tx_ready_o), 32'd0);
    endtask

    initial begin
        rst_ni     = 1'b0;
        bclk_i     = 1'b1;
        lrclk_i    = 1'b1;
        sdata_i    = 1'b0;
        tx_valid_i = 1'b0;
        tx_l_i     = '0;
        tx_r_i     = '0;
        sim_l      = '0;
        sim_r      = '0;
        repeat (4) @(negedge clk_i);
        check_reset_vals("reset");
        rst_ni = 1'b1;

        load_tx(16'h8001, 16'h7FFE);
        slot(1'b1, 16'h0000, SLOT, 1'b1, 16'h0000);
        // Frame 1: holding full at the left start, no underrun
        slot(1'b0, 16'hA5C3, SLOT, 1'b1, 16'h8001);
        slot(1'b1, 16'h5A3C, SLOT, 1'b1, 16'h7FFE);
        // Frame 2: previous pair published, holding empty from now on
        rx_exp_q.push_back('{l: 16'hA5C3, r: 16'h5A3C});
        under_exp_q.push_back(2);
        slot(1'b0, 16'h1234, SLOT, 1'b1, 16'h8001);
        slot(1'b1, 16'h4321, SLOT, 1'b1, 16'h7FFE);
        // Frame 3: short left slot
        rx_exp_q.push_back('{l: 16'h1234, r: 16'h4321});
        under_exp_q.push_back(3);
        slot(1'b0, 16'hFFFF, 10, 1'b0, 16'h0000);
        ferr_exp_q.push_back(3);
        slot(1'b1, 16'hBEEF, SLOT, 1'b1, 16'h7FFE);
        // Frame 4: errored pair is never published
        under_exp_q.push_back(4);
        slot(1'b0, 16'h0F0F, SLOT, 1'b1, 16'h8001);
        slot(1'b1, 16'hF0F0, SLOT, 1'b1, 16'h7FFE);
        // Frame 5: reset in the middle of the right slot
        rx_exp_q.push_back('{l: 16'h0F0F, r: 16'hF0F0});
        under_exp_q.push_back(5);
        slot(1'b0, 16'h1111, SLOT, 1'b1, 16'h8001);
        slot(1'b1, 16'h2222, 16, 1'b0, 16'h0000);
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        check_reset_vals("midreset");
        rst_ni = 1'b1;
        slot(1'b1, 16'h0000, 16, 1'b0, 16'h0000);
        // Frame 6: accept coincides with the left start while holding is empty
        sim_l      = 16'h1357;
        sim_r      = 16'h9BDF;
        sim_accept = 1'b1;
        under_exp_q.push_back(6);
        slot(1'b0, 16'hCAFE, SLOT, 1'b1, 16'h0000);
        check("tx_ready_hold_full", 32'(tx_ready_o), 32'd0);
        slot(1'b1, 16'hBABE, SLOT, 1'b1, 16'h0000);
        // Frame 7: pair accepted at frame 6 goes out now
        rx_exp_q.push_back('{l: 16'hCAFE, r: 16'hBABE});
        slot(1'b0, 16'h0123, SLOT, 1'b1, 16'h1357);
        check("tx_ready_after_left", 32'(tx_ready_o), 32'd1);
        slot(1'b1, 16'h4567, SLOT, 1'b1, 16'h9BDF);
        // Frame 8: only the left start, to publish frame 7
        rx_exp_q.push_back('{l: 16'h0123, r: 16'h4567});
        under_exp_q.push_back(8);
        slot(1'b0, 16'h0000, 4, 1'b0, 16'h0000);
        repeat (20) @(negedge clk_i);

        check("rx_pending",       32'(rx_exp_q.size()),    32'd0);
        check("underrun_pending", 32'(under_exp_q.size()), 32'd0);
        check("frame_err_pending", 32'(ferr_exp_q.size()), 32'd0);
        check("tx_pending",       32'(tx_exp_q.size()),    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
